xbar_output_port: RTL and testbench

//  Per-output-port packet mux of the crossbar, paired with one round-robin arbiter. Raises one request per

---
 rtl/xbar_output_port.sv | 157 +++++++++++++++
 tb/tb_xbar_output_port.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_output_port.sv
// Per-output-port packet mux of the crossbar: requests the arbiter, locks onto the granted
// input for one whole packet, and forwards its beats through a 2-entry first-word-fall-through FIFO.
module xbar_output_port #(
  parameter int P_WIDTH  = 3,
  parameter int P_DATA_W = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [P_WIDTH*P_DATA_W-1:0] data_i,
  input  logic [P_WIDTH-1:0]          valid_i,
  input  logic [P_WIDTH-1:0]          last_i,
  output logic [P_WIDTH-1:0]          ready_o,
  output logic [P_WIDTH-1:0]          request_o,
  input  logic [P_WIDTH-1:0]          grant_i,
  output logic [P_DATA_W-1:0]         data_o,
  output logic                        valid_o,
  output logic                        last_o,
  input  logic                        ready_i,
  output logic [15:0]                 pkt_cnt_o,
  output logic                        err_o
);

  localparam int OW = (P_WIDTH > 1) ? $clog2(P_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;

  state_t              state;
  logic [OW-1:0]       owner;
  logic [P_WIDTH-1:0]  owner_oh;
  logic [15:0]         pkt_cnt;
  logic                err;

  logic [P_DATA_W-1:0] fifo_data [2];
  logic [1:0]          fifo_last;
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count;

  logic                sel_valid;
  logic                sel_last;
  logic [P_DATA_W-1:0] sel_data;
  logic [OW-1:0]       grant_idx;
  logic                grant_ok;
  logic                fifo_full;
  logic                push;
  logic                pop;

  assign owner_oh  = P_WIDTH'(1) << owner;
  assign fifo_full = (count == 2'd2);
  assign grant_ok  = $onehot(grant_i) && ((grant_i & request_o) != '0);

  // Route the owning input's beat and decode the grant index.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    grant_idx = '0;
    for (int i = 0; i < P_WIDTH; i++) begin
      if (owner == OW'(i)) begin
        sel_valid = valid_i[i];
        sel_last  = last_i[i];
        sel_data  = data_i[i*P_DATA_W +: P_DATA_W];
      end
      if (grant_i[i]) begin
        grant_idx = OW'(i);
      end
    end
  end

  // In XFER the request stays on the owner regardless of valid_i so the arbiter keeps its grant.
  always_comb begin
    request_o = '0;
    ready_o   = '0;
    case (state)
      IDLE:    request_o = valid_i;
      XFER: begin
        request_o = owner_oh;
        if (!fifo_full) begin
          ready_o = owner_oh;
        end
      end
      default: begin
        request_o = '0;
        ready_o   = '0;
      end
    endcase
  end

  assign push = (state == XFER) && sel_valid && !fifo_full;
  assign pop  = valid_o && ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      owner   <= '0;
      pkt_cnt <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ok) begin
            owner <= grant_idx;
            state <= XFER;
          end else if (grant_i != '0) begin
            err <= 1'b1;
          end
        end
        XFER: begin
          if (grant_i != owner_oh) begin
            err <= 1'b1;
          end
          if (push && sel_last) begin
            state   <= RELEASE;
            pkt_cnt <= pkt_cnt + 16'd1;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr] <= sel_data;
      fifo_last[wr_ptr] <= sel_last;
    end
  end

  assign valid_o   = (count != 2'd0);
  assign data_o    = valid_o ? fifo_data[rd_ptr] : '0;
  assign last_o    = valid_o ? fifo_last[rd_ptr] : 1'b0;
  assign pkt_cnt_o = pkt_cnt;
  assign err_o     = err;

endmodule

// File: tb/tb_xbar_output_port.sv
// Bench for xbar_output_port: randomized packets driven into a round-robin arbiter model,
// with the output stream compared against a packet-level round-robin reference.
module tb_xbar_output_port;

  localparam int W  = 3;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_in = 1'b1;
  logic [W*DW-1:0] data_in = '0;
  logic [W-1:0]  valid_in = '0;
  logic [W-1:0]  last_in = '0;
  logic [W-1:0]  ready_out;
  logic [W-1:0]  request_out;
  logic [W-1:0]  grant;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          last_out;
  logic          ready_in = 1'b1;
  logic [15:0]   pkt_cnt_out;
  logic          err_out;

  xbar_output_port #(.P_WIDTH(W), .P_DATA_W(DW)) dut (
    .clk_i     (clk),
    .rst_i     (rst_in),
    .data_i    (data_in),
    .valid_i   (valid_in),
    .last_i    (last_in),
    .ready_o   (ready_out),
    .request_o (request_out),
    .grant_i   (grant),
    .data_o    (data_out),
    .valid_o   (valid_out),
    .last_o    (last_out),
    .ready_i   (ready_in),
    .pkt_cnt_o (pkt_cnt_out),
    .err_o     (err_out)
  );

  always #5 clk = ~clk;

  // Round-robin arbiter: first requester at or after the pointer wins; pointer moves past the winner.
  logic [1:0]   arb_ptr;
  logic [W-1:0] arb_grant;
  logic         manual = 1'b0;
  logic [W-1:0] grant_man = '0;

  always_comb begin
    arb_grant = '0;
    for (int off = 0; off < W; off++) begin
      if (arb_grant == '0 && request_out[(int'(arb_ptr) + off) % W]) begin
        arb_grant[(int'(arb_ptr) + off) % W] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      arb_ptr <= '0;
    end else begin
      for (int k = 0; k < W; k++) begin
        if (arb_grant[k]) begin
          arb_ptr <= 2'((k + 1) % W);
        end
      end
    end
  end

  assign grant = manual ? grant_man : arb_grant;

  typedef struct {
    int            cyc;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic [DW:0]  srcq [W][$];
  logic [DW:0]  modq [W][$];
  logic [DW:0]  expq [$];
  beat_t        outq [$];
  logic [W-1:0] req_log [$];
  logic [W-1:0] rdy_log [$];
  int           sent [W];
  int           gap_input, gap_after, gap_left;
  int           stall_from, stall_to;
  bit           rand_ready;
  bit           prev_stall;
  logic [DW-1:0] prev_data;
  logic         prev_last;
  int           cyc;
  int           exp_pkts;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic do_reset();
    @(negedge clk);
    rst_in    = 1'b1;
    manual    = 1'b0;
    grant_man = '0;
    valid_in  = '0;
    last_in   = '0;
    data_in   = '0;
    ready_in  = 1'b1;
    for (int k = 0; k < W; k++) begin
      srcq[k].delete();
      modq[k].delete();
      sent[k] = 0;
    end
    outq.delete();
    req_log.delete();
    rdy_log.delete();
    gap_input = -1; gap_after = 0; gap_left = 0;
    stall_from = 0; stall_to = 0;
    rand_ready = 1'b0; prev_stall = 1'b0;
    cyc = 0; exp_pkts = 0;
    @(negedge clk);
    @(negedge clk);
    rst_in = 1'b0;
  endtask

  task automatic load_pkt(input int k, input int len);
    logic [DW:0] v;
    for (int b = 0; b < len; b++) begin
      v = {(b == len - 1) ? 1'b1 : 1'b0, DW'($urandom)};
      srcq[k].push_back(v);
      modq[k].push_back(v);
    end
    exp_pkts++;
  endtask

  // Packet-level reference: whole packets leave in round-robin order over inputs with work pending.
  task automatic build_expected();
    int ptr;
    bit any;
    logic [DW:0] b;
    ptr = 0;
    expq.delete();
    while (1) begin
      any = 1'b0;
      for (int off = 0; off < W && !any; off++) begin
        int k;
        k = (ptr + off) % W;
        if (modq[k].size() > 0) begin
          any = 1'b1;
          do begin
            b = modq[k].pop_front();
            expq.push_back(b);
          end while (!b[DW]);
          ptr = (k + 1) % W;
        end
      end
      if (!any) break;
    end
  endtask

  // Drives sources and downstream ready each cycle; logs handshakes and checks stall stability.
  task automatic run(input int max_cycles, input int target, output bit timed_out);
    int n;
    logic [DW:0] dummy;
    beat_t bt;
    n = 0;
    timed_out = 1'b0;
    while (target < 0 || outq.size() < target) begin
      if (n >= max_cycles) begin
        timed_out = (target >= 0);
        break;
      end
      @(negedge clk);
      for (int k = 0; k < W; k++) begin
        valid_in[k] = 1'b0;
        last_in[k]  = 1'b0;
        data_in[k*DW +: DW] = '0;
        if (k == gap_input && sent[k] == gap_after && gap_left > 0) begin
          gap_left--;
        end else if (srcq[k].size() > 0) begin
          valid_in[k] = 1'b1;
          last_in[k]  = srcq[k][0][DW];
          data_in[k*DW +: DW] = srcq[k][0][DW-1:0];
        end
      end
      ready_in = (cyc >= stall_from && cyc < stall_to) ? 1'b0 :
                 (rand_ready ? 1'(($urandom % 4) != 0) : 1'b1);
      #1;
      req_log.push_back(request_out);
      rdy_log.push_back(ready_out);
      if (prev_stall) begin
        n_checks++;
        if (valid_out !== 1'b1 || data_out !== prev_data || last_out !== prev_last) begin
          n_fail++;
          $display("[TB] FAIL stall_hold cyc %0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   cyc, valid_out, data_out, last_out, prev_data, prev_last);
        end
      end
      for (int k = 0; k < W; k++) begin
        if (valid_in[k] && ready_out[k]) begin
          dummy = srcq[k].pop_front();
          sent[k]++;
        end
      end
      if (valid_out && ready_in) begin
        bt.cyc = cyc; bt.last = last_out; bt.data = data_out;
        outq.push_back(bt);
      end
      prev_stall = valid_out && !ready_in;
      prev_data  = data_out;
      prev_last  = last_out;
      cyc++;
      n++;
    end
  endtask

  task automatic test_reset();
    bit to;
    do_reset();
    #1;
    n_checks++;
    if (valid_out !== 1'b0 || data_out !== '0 || last_out !== 1'b0 || ready_out !== '0 ||
        request_out !== '0 || pkt_cnt_out !== 16'd0 || err_out !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_values: got v=%b d=%h l=%b rdy=%b req=%b cnt=%h err=%b want all zero",
               valid_out, data_out, last_out, ready_out, request_out, pkt_cnt_out, err_out);
    end
    load_pkt(0, 6);
    stall_from = 0;
    stall_to   = 1000;
    run(4, -1, to);
    n_checks++;
    if (valid_out !== 1'b1 || ready_out !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL reset_prefull: got v=%b rdy=%b want v=1 rdy=000", valid_out, ready_out);
    end
    rst_in = 1'b1;
    #1;
    n_checks++;
    if (valid_out !== 1'b0 || data_out !== '0 || last_out !== 1'b0 || ready_out !== '0 ||
        request_out !== 3'b001 || pkt_cnt_out !== 16'd0 || err_out !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_async: got v=%b d=%h l=%b rdy=%b req=%b cnt=%h err=%b want 0/0/0/000/001/0/0",
               valid_out, data_out, last_out, ready_out, request_out, pkt_cnt_out, err_out);
    end
    do_reset();
    @(negedge clk);
    #1;
    n_checks++;
    if (valid_out !== 1'b0 || data_out !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_fifo_empty: got v=%b d=%h want v=0 d=0", valid_out, data_out);
    end
  endtask

  task automatic test_single();
    bit to;
    do_reset();
    load_pkt(1, 4);
    build_expected();
    run(100, 4, to);
    run(3, -1, to);
    n_checks++;
    if (to) begin n_fail++; $display("[TB] FAIL single_timeout: got %0d beats want 4", outq.size()); end
    n_checks++;
    if (outq.size() !== expq.size()) begin
      n_fail++;
      $display("[TB] FAIL single_len: got %0d want %0d", outq.size(), expq.size());
    end
    for (int i = 0; i < outq.size() && i < expq.size(); i++) begin
      n_checks++;
      if ({outq[i].last, outq[i].data} !== expq[i] || outq[i].cyc !== 2 + i) begin
        n_fail++;
        $display("[TB] FAIL single_beat%0d: got %h@%0d want %h@%0d", i,
                 {outq[i].last, outq[i].data}, outq[i].cyc, expq[i], 2 + i);
      end
    end
    for (int c = 0; c <= 6; c++) begin
      n_checks++;
      if (req_log[c] !== ((c <= 4) ? 3'b010 : 3'b000)) begin
        n_fail++;
        $display("[TB] FAIL single_req cyc %0d: got %b want %b", c, req_log[c],
                 (c <= 4) ? 3'b010 : 3'b000);
      end
    end
    n_checks++;
    if (pkt_cnt_out !== 16'(exp_pkts)) begin
      n_fail++;
      $display("[TB] FAIL single_pkt_cnt: got %0d want %0d", pkt_cnt_out, exp_pkts);
    end
  endtask

  task automatic test_contention();
    bit to;
    int want;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < W; k++) load_pkt(k, 2);
    end
    build_expected();
    run(400, expq.size(), to);
    n_checks++;
    if (to || outq.size() !== expq.size()) begin
      n_fail++;
      $display("[TB] FAIL contention_len: got %0d want %0d", outq.size(), expq.size());
    end
    for (int i = 0; i < outq.size() && i < expq.size(); i++) begin
      n_checks++;
      if ({outq[i].last, outq[i].data} !== expq[i]) begin
        n_fail++;
        $display("[TB] FAIL contention_beat%0d: got %h want %h", i, {outq[i].last, outq[i].data}, expq[i]);
      end
    end
    for (int i = 1; i < outq.size(); i++) begin
      want = outq[i-1].last ? 3 : 1;
      n_checks++;
      if (outq[i].cyc - outq[i-1].cyc !== want) begin
        n_fail++;
        $display("[TB] FAIL contention_spacing%0d: got %0d want %0d", i, outq[i].cyc - outq[i-1].cyc, want);
      end
    end
    run(4, -1, to);
    n_checks++;
    if (pkt_cnt_out !== 16'(exp_pkts)) begin
      n_fail++;
      $display("[TB] FAIL contention_pkt_cnt: got %0d want %0d", pkt_cnt_out, exp_pkts);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    do_reset();
    load_pkt(2, 6);
    build_expected();
    stall_from = 1;
    stall_to   = 6;
    run(200, 6, to);
    n_checks++;
    if (to || outq.size() !== expq.size()) begin
      n_fail++;
      $display("[TB] FAIL bp_len: got %0d want %0d", outq.size(), expq.size());
    end
    for (int i = 0; i < outq.size() && i < expq.size(); i++) begin
      n_checks++;
      if ({outq[i].last, outq[i].data} !== expq[i]) begin
        n_fail++;
        $display("[TB] FAIL bp_beat%0d: got %h want %h", i, {outq[i].last, outq[i].data}, expq[i]);
      end
    end
    for (int c = 1; c <= 3; c++) begin
      n_checks++;
      if (rdy_log[c] !== ((c < 3) ? 3'b100 : 3'b000)) begin
        n_fail++;
        $display("[TB] FAIL bp_ready cyc %0d: got %b want %b", c, rdy_log[c], (c < 3) ? 3'b100 : 3'b000);
      end
    end
  endtask

  task automatic test_valid_gap();
    bit to;
    do_reset();
    load_pkt(0, 5);
    load_pkt(1, 2);
    load_pkt(2, 2);
    build_expected();
    gap_input = 0;
    gap_after = 2;
    gap_left  = 3;
    run(300, expq.size(), to);
    n_checks++;
    if (to || outq.size() !== expq.size()) begin
      n_fail++;
      $display("[TB] FAIL gap_len: got %0d want %0d", outq.size(), expq.size());
    end
    for (int i = 0; i < outq.size() && i < expq.size(); i++) begin
      n_checks++;
      if ({outq[i].last, outq[i].data} !== expq[i]) begin
        n_fail++;
        $display("[TB] FAIL gap_beat%0d: got %h want %h", i, {outq[i].last, outq[i].data}, expq[i]);
      end
    end
    for (int c = 1; c <= 9; c++) begin
      n_checks++;
      if (req_log[c] !== ((c <= 8) ? 3'b001 : 3'b000)) begin
        n_fail++;
        $display("[TB] FAIL gap_req cyc %0d: got %b want %b", c, req_log[c], (c <= 8) ? 3'b001 : 3'b000);
      end
    end
  endtask

  task automatic test_random();
    bit to;
    do_reset();
    for (int k = 0; k < W; k++) begin
      for (int p = 0; p < 2 + int'($urandom_range(1)); p++) load_pkt(k, 1 + int'($urandom_range(4)));
    end
    build_expected();
    rand_ready = 1'b1;
    run(3000, expq.size(), to);
    run(4, -1, to);
    n_checks++;
    if (outq.size() !== expq.size()) begin
      n_fail++;
      $display("[TB] FAIL random_len: got %0d want %0d", outq.size(), expq.size());
    end
    for (int i = 0; i < outq.size() && i < expq.size(); i++) begin
      n_checks++;
      if ({outq[i].last, outq[i].data} !== expq[i]) begin
        n_fail++;
        $display("[TB] FAIL random_beat%0d: got %h want %h", i, {outq[i].last, outq[i].data}, expq[i]);
      end
    end
    n_checks++;
    if (pkt_cnt_out !== 16'(exp_pkts) || err_out !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL random_status: got cnt=%0d err=%b want cnt=%0d err=0", pkt_cnt_out, err_out, exp_pkts);
    end
  endtask

  task automatic test_errors_wrap();
    bit to;
    logic [15:0] want_cnt;
    do_reset();
    manual = 1'b1;
    @(negedge clk);
    valid_in  = 3'b011;
    grant_man = 3'b011;
    #1;
    n_checks++;
    if (request_out !== 3'b011 || err_out !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL err_before: got req=%b err=%b want req=011 err=0", request_out, err_out);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (err_out !== 1'b1 || ready_out !== 3'b000 || request_out !== 3'b011) begin
      n_fail++;
      $display("[TB] FAIL err_multihot: got err=%b rdy=%b req=%b want err=1 rdy=000 req=011",
               err_out, ready_out, request_out);
    end
    valid_in  = '0;
    grant_man = '0;
    manual    = 1'b0;
    force dut.pkt_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.pkt_cnt;
    #1;
    n_checks++;
    if (pkt_cnt_out !== 16'hFFFF) begin
      n_fail++;
      $display("[TB] FAIL wrap_preload: got %h want ffff", pkt_cnt_out);
    end
    load_pkt(2, 1);
    build_expected();
    run(50, 1, to);
    run(3, -1, to);
    want_cnt = 16'hFFFF;
    want_cnt = want_cnt + 16'd1;
    n_checks++;
    if (to || outq.size() !== 1 || {outq[0].last, outq[0].data} !== expq[0]) begin
      n_fail++;
      $display("[TB] FAIL wrap_beat: got %0d beats want 1 beat %h", outq.size(), expq[0]);
    end
    n_checks++;
    if (pkt_cnt_out !== want_cnt || err_out !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wrap_count: got cnt=%h err=%b want cnt=%h err=1", pkt_cnt_out, err_out, want_cnt);
    end
  endtask

  initial begin
    $display("[TB] xbar_output_port bench start");
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_valid_gap();
    test_random();
    test_errors_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
